// File: rtl/spi_adc_frontend.sv
`default_nettype none
// ============================================================================
// Module   : spi_adc_frontend
// Purpose  : Periodic SPI read of a serial ADC, offset-binary conversion and
//            valid/ready sample hold register with saturating overrun count.
// Revision : 1.0
// ============================================================================
module spi_adc_frontend #(
    parameter int CLK_DIV       = 4,
    parameter int FRAME_BITS    = 16,
    parameter int SAMPLE_PERIOD = 256,
    parameter bit OFFSET_BINARY = 1'b1
) (
    input  logic                  input_clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  spi_miso,
    output logic                  spi_sclk,
    output logic                  spi_cs,
    output logic                  spi_mosi,
    output logic [FRAME_BITS-1:0] sample_data,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic [7:0]            overrun_count
);
    localparam int c_TIMER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int c_PH_W    = $clog2(CLK_DIV);
    localparam int c_BIT_W   = $clog2(FRAME_BITS + 1);

    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(SAMPLE_PERIOD - 1);
    localparam logic [c_PH_W-1:0]    c_PH_LAST    = c_PH_W'(CLK_DIV - 1);
    localparam logic [c_PH_W-1:0]    c_PH_HALF    = c_PH_W'(CLK_DIV / 2);
    localparam logic [c_BIT_W-1:0]   c_BIT_LAST   = c_BIT_W'(FRAME_BITS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state_q,  w_state_d;
    logic [c_TIMER_W-1:0]   r_timer_q,  w_timer_d;
    logic [c_PH_W-1:0]      r_ph_q,     w_ph_d;
    logic [c_BIT_W-1:0]     r_bit_q,    w_bit_d;
    logic [FRAME_BITS-1:0]  r_shift_q,  w_shift_d;
    logic                   r_cs_q,     w_cs_d;
    logic                   r_sclk_q,   w_sclk_d;
    logic [FRAME_BITS-1:0]  r_data_q,   w_data_d;
    logic                   r_valid_q,  w_valid_d;
    logic [7:0]             r_ovr_q,    w_ovr_d;
    logic                   w_load;
    logic [FRAME_BITS-1:0]  w_conv;

    generate
        if (OFFSET_BINARY) begin : g_offset
            assign w_conv = {~w_shift_d[FRAME_BITS-1], w_shift_d[FRAME_BITS-2:0]};
        end else begin : g_pass
            assign w_conv = w_shift_d;
        end
    endgenerate

    always_comb begin
        w_timer_d = (r_timer_q == c_TIMER_LAST) ? '0 : r_timer_q + 1'b1;
        w_state_d = r_state_q;
        w_ph_d    = r_ph_q;
        w_bit_d   = r_bit_q;
        w_shift_d = r_shift_q;
        w_load    = 1'b0;

        // bit counter holds the SCLK period index: 0 is setup, 1..FRAME_BITS carry data
        unique case (r_state_q)
            S_IDLE: begin
                if (r_timer_q == '0 && enable) begin
                    w_state_d = S_SETUP;
                    w_ph_d    = '0;
                    w_bit_d   = '0;
                end
            end
            S_SETUP: begin
                if (r_ph_q == c_PH_LAST) begin
                    w_state_d = S_SHIFT;
                    w_ph_d    = '0;
                    w_bit_d   = c_BIT_W'(1);
                end else begin
                    w_ph_d = r_ph_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (r_ph_q == c_PH_LAST) begin
                    w_shift_d = {r_shift_q[FRAME_BITS-2:0], spi_miso};
                    w_ph_d    = '0;
                    if (r_bit_q == c_BIT_LAST) begin
                        w_state_d = S_DONE;
                        w_load    = 1'b1;
                    end else begin
                        w_bit_d = r_bit_q + 1'b1;
                    end
                end else begin
                    w_ph_d = r_ph_q + 1'b1;
                end
            end
            S_DONE:  w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase

        // pins are registered from next-state so they line up with the state flops
        w_cs_d   = !(w_state_d == S_SETUP || w_state_d == S_SHIFT);
        w_sclk_d = !(w_state_d == S_SHIFT && w_ph_d < c_PH_HALF);

        w_data_d  = r_data_q;
        w_valid_d = r_valid_q;
        w_ovr_d   = r_ovr_q;
        if (w_load) begin
            w_data_d  = w_conv;
            w_valid_d = 1'b1;
            if (r_valid_q && !sample_ready && r_ovr_q != 8'hFF) begin
                w_ovr_d = r_ovr_q + 8'd1;
            end
        end else if (r_valid_q && sample_ready) begin
            w_valid_d = 1'b0;
        end
    end

    always_ff @(posedge input_clk) begin
        if (reset) begin
            r_state_q <= S_IDLE;
            r_timer_q <= '0;
            r_ph_q    <= '0;
            r_bit_q   <= '0;
            r_shift_q <= '0;
            r_cs_q    <= 1'b1;
            r_sclk_q  <= 1'b1;
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
            r_ovr_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_timer_q <= w_timer_d;
            r_ph_q    <= w_ph_d;
            r_bit_q   <= w_bit_d;
            r_shift_q <= w_shift_d;
            r_cs_q    <= w_cs_d;
            r_sclk_q  <= w_sclk_d;
            r_data_q  <= w_data_d;
            r_valid_q <= w_valid_d;
            r_ovr_q   <= w_ovr_d;
        end
    end

    assign spi_cs        = r_cs_q;
    assign spi_sclk      = r_sclk_q;
    assign spi_mosi      = 1'b0;
    assign sample_data   = r_data_q;
    assign sample_valid  = r_valid_q;
    assign overrun_count = r_ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_adc_frontend.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_adc_frontend
// Purpose  : Self-checking bench for spi_adc_frontend with an ADC model and
//            a scoreboard of expected samples per frame.
// Revision : 1.0
// ============================================================================
module tb_spi_adc_frontend;
    logic input_clk    = 1'b0;
    logic reset        = 1'b1;
    logic enable       = 1'b0;
    logic sample_ready = 1'b0;
    logic spi_miso     = 1'b0;

    logic        spi_sclk, spi_cs, spi_mosi, sample_valid;
    logic [15:0] sample_data;
    logic [7:0]  overrun_count;
    logic        pt_sclk, pt_cs, pt_mosi, pt_valid;
    logic [15:0] pt_data;
    logic [7:0]  pt_ovr;

    always #5 input_clk = ~input_clk;

    spi_adc_frontend u_dut (
        .input_clk(input_clk), .reset(reset), .enable(enable), .spi_miso(spi_miso),
        .spi_sclk(spi_sclk), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
        .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .overrun_count(overrun_count)
    );

    spi_adc_frontend #(.OFFSET_BINARY(1'b0)) u_dut_pt (
        .input_clk(input_clk), .reset(reset), .enable(enable), .spi_miso(spi_miso),
        .spi_sclk(pt_sclk), .spi_cs(pt_cs), .spi_mosi(pt_mosi),
        .sample_data(pt_data), .sample_valid(pt_valid),
        .sample_ready(sample_ready), .overrun_count(pt_ovr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // ADC model: word fetched at CS fall, next bit driven on each SCLK fall
    logic [15:0] adc_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] raw_q[$];
    logic [15:0] adc_word = 16'h0000;
    int          adc_idx  = 0;

    always @(negedge spi_cs) begin
        if (!reset) begin
            if (adc_q.size() > 0) adc_word = adc_q.pop_front();
            else adc_word = 16'h8000;
            adc_idx = 0;
            exp_q.push_back(adc_word ^ 16'h8000);
            raw_q.push_back(adc_word);
        end
    end

    always @(negedge spi_sclk) begin
        if (!spi_cs && adc_idx < 16) begin
            spi_miso = adc_word[15 - adc_idx];
            adc_idx++;
        end
    end

    // Monitor: behavioural model of the hold register, checked every cycle
    logic        m_valid = 1'b0, m_prev_v = 1'b0, m_prev_rdy = 1'b0;
    logic        m_prev_cs = 1'b1, m_prev_sclk = 1'b1;
    logic [15:0] m_data = 16'h0000;
    logic [15:0] m_raw;
    int          m_ovr = 0, cyc = -1, low_cnt = 0, pulses = 0;
    int          n_loads = 0, n_falls = 0, last_fall = 0, last_load = 0;

    always @(negedge input_clk) begin
        if (reset) begin
            m_valid = 1'b0; m_prev_v = 1'b0; m_prev_rdy = 1'b0;
            m_prev_cs = 1'b1; m_prev_sclk = 1'b1; m_data = 16'h0000;
            m_ovr = 0; cyc = -1; low_cnt = 0; pulses = 0;
            exp_q.delete(); raw_q.delete();
        end else begin
            cyc++;
            if (m_prev_cs && !spi_cs) begin
                chk("cs_fall_phase", cyc % 256, 1);
                n_falls++; last_fall = cyc; low_cnt = 0; pulses = 0;
            end
            if (!spi_cs) low_cnt++;
            if (!spi_cs && m_prev_sclk && !spi_sclk) pulses++;
            if (spi_cs) chk("sclk_idle", spi_sclk, 1'b1);
            chk("mosi", spi_mosi, 1'b0);
            if (!m_prev_cs && spi_cs) begin
                n_loads++; last_load = cyc;
                chk("cs_low_cycles", low_cnt, 68);
                chk("sclk_pulses", pulses, 16);
                chk("sb_nonempty", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    m_data = exp_q.pop_front();
                    m_raw  = raw_q.pop_front();
                    chk("pt_data", pt_data, m_raw);
                    chk("pt_valid", pt_valid, 1'b1);
                end
                if (m_prev_v && !m_prev_rdy && m_ovr < 255) m_ovr++;
                m_valid = 1'b1;
                chk("pt_ovr", pt_ovr, m_ovr);
                chk("pt_idle", {pt_cs, pt_sclk, pt_mosi}, 3'b110);
            end else if (m_prev_v && m_prev_rdy) begin
                m_valid = 1'b0;
            end
            chk("valid", sample_valid, m_valid);
            chk("data", sample_data, m_data);
            chk("overrun", overrun_count, m_ovr);
            m_prev_v = m_valid; m_prev_rdy = sample_ready;
            m_prev_cs = spi_cs; m_prev_sclk = spi_sclk;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge input_clk);
        #1;
    endtask

    task automatic wait_load(input int bound);
        int start;
        int k;
        start = n_loads;
        k = 0;
        while (n_loads == start && k < bound) begin step(1); k++; end
        chk("wait_load_timeout", n_loads != start, 1'b1);
    endtask

    task automatic wait_cs_fall(input int bound);
        int k;
        k = 0;
        while (spi_cs && k < bound) begin step(1); k++; end
        chk("wait_cs_timeout", spi_cs, 1'b0);
    endtask

    logic [15:0] ob_in  [3] = '{16'hFFFF, 16'h0000, 16'hA5C3};
    logic [15:0] ob_exp [3] = '{16'h7FFF, 16'h8000, 16'h25C3};
    int          snap;

    initial begin
        step(3);
        chk("rst_cs", spi_cs, 1'b1);
        chk("rst_sclk", spi_sclk, 1'b1);
        chk("rst_mosi", spi_mosi, 1'b0);
        chk("rst_data", sample_data, 16'h0000);
        chk("rst_valid", sample_valid, 1'b0);
        chk("rst_ovr", overrun_count, 8'd0);

        // default 0x8000 frames, free-flowing consumer
        reset = 1'b0; enable = 1'b1; sample_ready = 1'b1;
        step(1);
        chk("cs_first_low", spi_cs, 1'b0);
        repeat (3) wait_load(300);
        chk("a_data", sample_data, 16'h0000);
        chk("a_ovr", overrun_count, 8'd0);

        // offset-binary mapping
        for (int i = 0; i < 3; i++) adc_q.push_back(ob_in[i]);
        for (int i = 0; i < 3; i++) begin
            wait_load(300);
            chk("ob_data", sample_data, ob_exp[i]);
        end
        chk("pt_passthru", pt_data, 16'hA5C3);

        // backpressure over three frames, then ready in frame 4's load cycle
        reset = 1'b1; sample_ready = 1'b0;
        step(1);
        reset = 1'b0;
        adc_q.push_back(16'h1111); adc_q.push_back(16'h2222);
        adc_q.push_back(16'h3333); adc_q.push_back(16'h4444);
        repeat (3) wait_load(300);
        chk("bp_data", sample_data, 16'hB333);
        chk("bp_valid", sample_valid, 1'b1);
        chk("bp_ovr", overrun_count, 8'd2);
        wait_cs_fall(300);
        step(67);
        sample_ready = 1'b1;
        step(1);
        sample_ready = 1'b0;
        chk("bp4_valid", sample_valid, 1'b1);
        chk("bp4_data", sample_data, 16'hC444);
        chk("bp4_ovr", overrun_count, 8'd2);
        step(2);
        sample_ready = 1'b1;
        step(3);
        chk("drain_valid", sample_valid, 1'b0);

        // saturation
        sample_ready = 1'b0;
        repeat (258) wait_load(300);
        chk("sat_ovr", overrun_count, 8'd255);
        sample_ready = 1'b1;

        // enable low across timer==0 skips the period
        enable = 1'b0;
        snap = n_falls;
        step(300);
        chk("skip_no_frame", n_falls, snap);
        enable = 1'b1;
        wait_cs_fall(300);
        step(20);
        enable = 1'b0;
        wait_load(100);
        chk("en_drop_latency", last_load - last_fall, 68);
        snap = n_falls;
        step(300);
        chk("en_off_no_frame", n_falls, snap);

        // reset in the middle of a frame
        enable = 1'b1;
        adc_q.push_back(16'hDEAD); adc_q.push_back(16'h1234);
        wait_cs_fall(300);
        step(30);
        reset = 1'b1;
        step(1);
        chk("mid_rst_cs", spi_cs, 1'b1);
        chk("mid_rst_sclk", spi_sclk, 1'b1);
        chk("mid_rst_valid", sample_valid, 1'b0);
        reset = 1'b0;
        snap = n_loads;
        step(60);
        chk("mid_rst_no_load", n_loads, snap);
        chk("mid_rst_valid2", sample_valid, 1'b0);
        wait_load(200);
        chk("post_rst_data", sample_data, 16'h9234);
        step(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
